// File: rtl/mrd_mem_pkt.sv
// Shared constants and types for the mixed-radix DFT memory write-back path.
package mrd_mem_pkt;
   localparam int wADDR = 9;
   localparam int NBANK = 7;
   localparam int NLANE = 5;
   localparam logic [2:0] BANK_INVALID = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WR    = 2'd1,
      ST_FLUSH = 2'd2
   } wr_state_e;
endpackage

// File: rtl/mrd_wr_bank_steer.sv
// Combinational lane-to-bank steering; lowest valid lane wins each bank.
// MRD_WR_COLLISION_CHK_EN adds the raw same-bank collision output.
module mrd_wr_bank_steer #(
   parameter int wDATA = 18,
   parameter int wADDR = mrd_mem_pkt::wADDR
) (
   input  logic                   vld,
   input  logic [2:0]             factor,
   input  logic [0:4][2:0]        bank_index,
   input  logic [0:4][wADDR-1:0]  bank_addr,
   input  logic [0:4][wDATA-1:0]  lane_real,
   input  logic [0:4][wDATA-1:0]  lane_imag,
   output logic [0:6]             wren,
   output logic [0:6][wADDR-1:0]  wraddr,
   output logic [0:6][wDATA-1:0]  wdata_real,
`ifdef MRD_WR_COLLISION_CHK_EN
   output logic [0:6][wDATA-1:0]  wdata_imag,
   output logic                   collision
`else
   output logic [0:6][wDATA-1:0]  wdata_imag
`endif
);
   import mrd_mem_pkt::*;

   always_comb begin
      wren       = '0;
      wraddr     = '0;
      wdata_real = '0;
      wdata_imag = '0;
`ifdef MRD_WR_COLLISION_CHK_EN
      collision  = 1'b0;
`endif
      // Lanes scanned in ascending order so the first claim on a bank sticks.
      for (int k = 0; k < NLANE; k++) begin
         if (vld && (3'(k) < factor) && (bank_index[k] != BANK_INVALID)) begin
            for (int b = 0; b < NBANK; b++) begin
               if (bank_index[k] == 3'(b)) begin
                  if (!wren[b]) begin
                     wren[b]       = 1'b1;
                     wraddr[b]     = bank_addr[k];
                     wdata_real[b] = lane_real[k];
                     wdata_imag[b] = lane_imag[k];
                  end
`ifdef MRD_WR_COLLISION_CHK_EN
                  else begin
                     collision = 1'b1;
                  end
`endif
               end
            end
         end
      end
   end
endmodule

// File: rtl/mrd_rdx2345_wrback.sv
// Write-back engine: registers butterfly beats, steers lanes onto 7 RAM banks,
// counts beats per stage and pulses wr_end. Optional macro: MRD_WR_COLLISION_CHK_EN.
module mrd_rdx2345_wrback #(
   parameter int wDATA = 18,
   parameter int wADDR = mrd_mem_pkt::wADDR
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [11:0]            cnt_wr_stop,
   input  logic                   in_valid,
   input  logic [2:0]             in_factor,
   input  logic [0:4][2:0]        in_bank_index,
   input  logic [0:4][wADDR-1:0]  in_bank_addr,
   input  logic [0:4][wDATA-1:0]  in_real,
   input  logic [0:4][wDATA-1:0]  in_imag,
   output logic [0:6]             wren,
   output logic [0:6][wADDR-1:0]  wraddr,
   output logic [0:6][wDATA-1:0]  wdata_real,
   output logic [0:6][wDATA-1:0]  wdata_imag,
   output logic                   wr_busy,
   output logic                   wr_end,
   output logic [11:0]            beat_cnt,
   output logic                   collision_err
);
   import mrd_mem_pkt::*;

   wr_state_e state_q, state_d;
   logic [11:0] beat_cnt_q, beat_cnt_d;
   logic        wr_end_q, wr_end_d;
   logic        accept, start_idle;

   logic                  vld_p1_q, vld_p1_d;
   logic [2:0]            factor_p1_q, factor_p1_d;
   logic [0:4][2:0]       idx_p1_q, idx_p1_d;
   logic [0:4][wADDR-1:0] addr_p1_q, addr_p1_d;
   logic [0:4][wDATA-1:0] re_p1_q, re_p1_d;
   logic [0:4][wDATA-1:0] im_p1_q, im_p1_d;

   logic [0:6]            wren_p2_q, wren_p2_d;
   logic [0:6][wADDR-1:0] wraddr_p2_q, wraddr_p2_d;
   logic [0:6][wDATA-1:0] wre_p2_q, wre_p2_d;
   logic [0:6][wDATA-1:0] wim_p2_q, wim_p2_d;

   assign accept     = in_valid && (state_q == ST_WR);
   assign start_idle = start && (state_q == ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = (cnt_wr_stop == 12'd0) ? ST_FLUSH : ST_WR;
         ST_WR:    if (accept && ((beat_cnt_q + 12'd1) == cnt_wr_stop)) state_d = ST_FLUSH;
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_busy = (state_q != ST_IDLE);
   end

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (start_idle)  beat_cnt_d = 12'd0;
      else if (accept) beat_cnt_d = beat_cnt_q + 12'd1;
      // The last beat leaves stage 2 on the same edge FLUSH expires.
      wr_end_d = (state_q == ST_FLUSH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt_q <= '0;
         wr_end_q   <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         wr_end_q   <= wr_end_d;
      end
   end

   // ---- stage 1: capture accepted beat ----
   always_comb begin
      vld_p1_d    = accept;
      factor_p1_d = factor_p1_q;
      idx_p1_d    = idx_p1_q;
      addr_p1_d   = addr_p1_q;
      re_p1_d     = re_p1_q;
      im_p1_d     = im_p1_q;
      if (accept) begin
         factor_p1_d = in_factor;
         idx_p1_d    = in_bank_index;
         addr_p1_d   = in_bank_addr;
         re_p1_d     = in_real;
         im_p1_d     = in_imag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) vld_p1_q <= 1'b0;
      else        vld_p1_q <= vld_p1_d;
   end

   always_ff @(posedge clk) begin
      factor_p1_q <= factor_p1_d;
      idx_p1_q    <= idx_p1_d;
      addr_p1_q   <= addr_p1_d;
      re_p1_q     <= re_p1_d;
      im_p1_q     <= im_p1_d;
   end

   // ---- stage 1 -> stage 2: bank steering ----
`ifdef MRD_WR_COLLISION_CHK_EN
   logic coll_raw;
   logic coll_q, coll_d;
`endif

   mrd_wr_bank_steer #(.wDATA(wDATA), .wADDR(wADDR)) u_steer (
      .vld        (vld_p1_q),
      .factor     (factor_p1_q),
      .bank_index (idx_p1_q),
      .bank_addr  (addr_p1_q),
      .lane_real  (re_p1_q),
      .lane_imag  (im_p1_q),
      .wren       (wren_p2_d),
      .wraddr     (wraddr_p2_d),
      .wdata_real (wre_p2_d),
`ifdef MRD_WR_COLLISION_CHK_EN
      .wdata_imag (wim_p2_d),
      .collision  (coll_raw)
`else
      .wdata_imag (wim_p2_d)
`endif
   );

   // ---- stage 2: registered bank outputs ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wren_p2_q   <= '0;
         wraddr_p2_q <= '0;
         wre_p2_q    <= '0;
         wim_p2_q    <= '0;
      end else begin
         wren_p2_q   <= wren_p2_d;
         wraddr_p2_q <= wraddr_p2_d;
         wre_p2_q    <= wre_p2_d;
         wim_p2_q    <= wim_p2_d;
      end
   end

`ifdef MRD_WR_COLLISION_CHK_EN
   always_comb begin
      coll_d = coll_q;
      if (start_idle)    coll_d = 1'b0;
      else if (coll_raw) coll_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) coll_q <= 1'b0;
      else        coll_q <= coll_d;
   end

   assign collision_err = coll_q;
`else
   assign collision_err = 1'b0;
`endif

   assign wren       = wren_p2_q;
   assign wraddr     = wraddr_p2_q;
   assign wdata_real = wre_p2_q;
   assign wdata_imag = wim_p2_q;
   assign wr_end     = wr_end_q;
   assign beat_cnt   = beat_cnt_q;
endmodule

// File: tb/tb_mrd_rdx2345_wrback.sv
// Randomized bench for mrd_rdx2345_wrback with a cycle-indexed behavioural model.
module tb_mrd_rdx2345_wrback;
   import mrd_mem_pkt::*;
   localparam int WD = 18;
   localparam int WA = wADDR;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [11:0]         cnt_wr_stop = '0;
   logic                in_valid = 1'b0;
   logic [2:0]          in_factor = '0;
   logic [0:4][2:0]     in_bank_index = '0;
   logic [0:4][WA-1:0]  in_bank_addr = '0;
   logic [0:4][WD-1:0]  in_real = '0;
   logic [0:4][WD-1:0]  in_imag = '0;
   logic [0:6]          wren;
   logic [0:6][WA-1:0]  wraddr;
   logic [0:6][WD-1:0]  wdata_real;
   logic [0:6][WD-1:0]  wdata_imag;
   logic                wr_busy, wr_end, collision_err;
   logic [11:0]         beat_cnt;

   mrd_rdx2345_wrback #(.wDATA(WD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cnt_wr_stop(cnt_wr_stop),
      .in_valid(in_valid), .in_factor(in_factor), .in_bank_index(in_bank_index),
      .in_bank_addr(in_bank_addr), .in_real(in_real), .in_imag(in_imag),
      .wren(wren), .wraddr(wraddr), .wdata_real(wdata_real), .wdata_imag(wdata_imag),
      .wr_busy(wr_busy), .wr_end(wr_end), .beat_cnt(beat_cnt), .collision_err(collision_err)
   );

   always #5 clk = ~clk;

`ifdef MRD_WR_COLLISION_CHK_EN
   localparam bit COLL_ON = 1'b1;
`else
   localparam bit COLL_ON = 1'b0;
`endif

   typedef struct {
      logic [0:6]         wren;
      logic [0:6][WA-1:0] addr;
      logic [0:6][WD-1:0] re;
      logic [0:6][WD-1:0] im;
   } wexp_t;

   // Expectations keyed by the cycle (posedge count) at which they become visible.
   wexp_t exp_w [int];
   bit    exp_end [int];
   bit    coll_set [int];

   int cyc = 0;
   int m_mode = 0;   // 0 idle, 1 writing, 2 flushing
   int m_cnt = 0;
   bit m_coll = 1'b0;
   int n_tests = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic check_outputs();
      wexp_t w;
      w.wren = '0; w.addr = '0; w.re = '0; w.im = '0;
      if (exp_w.exists(cyc)) w = exp_w[cyc];
      chk("wren", 64'(wren), 64'(w.wren));
      for (int b = 0; b < 7; b++) begin
         chk($sformatf("wraddr%0d", b), 64'(wraddr[b]), 64'(w.addr[b]));
         chk($sformatf("wdata_real%0d", b), 64'(wdata_real[b]), 64'(w.re[b]));
         chk($sformatf("wdata_imag%0d", b), 64'(wdata_imag[b]), 64'(w.im[b]));
      end
      chk("wr_busy", 64'(wr_busy), 64'(m_mode != 0));
      chk("wr_end", 64'(wr_end), 64'(exp_end.exists(cyc)));
      chk("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
      chk("collision_err", 64'(collision_err), 64'(m_coll & COLL_ON));
   endtask

   // Predict the effect of the upcoming posedge given the inputs currently driven.
   task automatic model_step();
      int t;
      wexp_t w;
      int hits [7];
      bit coll;
      t = cyc + 1;
      if (!rst_n) begin
         m_mode = 0; m_cnt = 0; m_coll = 1'b0;
         exp_w.delete(t); exp_w.delete(t + 1);
         exp_end.delete(t); exp_end.delete(t + 1);
         coll_set.delete(t); coll_set.delete(t + 1);
         return;
      end
      if (coll_set.exists(t)) m_coll = 1'b1;
      case (m_mode)
         0: if (start) begin
               m_cnt = 0;
               m_coll = 1'b0;
               if (cnt_wr_stop == 0) begin
                  m_mode = 2;
                  exp_end[t + 1] = 1'b1;
               end else begin
                  m_mode = 1;
               end
            end
         1: if (in_valid) begin
               w.wren = '0; w.addr = '0; w.re = '0; w.im = '0;
               for (int b = 0; b < 7; b++) hits[b] = 0;
               // Walk lanes high to low so the lowest lane overwrites last.
               for (int k = 4; k >= 0; k--) begin
                  if (k < int'(in_factor) && in_bank_index[k] != 3'd7) begin
                     hits[in_bank_index[k]]++;
                     w.wren[in_bank_index[k]] = 1'b1;
                     w.addr[in_bank_index[k]] = in_bank_addr[k];
                     w.re[in_bank_index[k]]   = in_real[k];
                     w.im[in_bank_index[k]]   = in_imag[k];
                  end
               end
               coll = 1'b0;
               for (int b = 0; b < 7; b++) if (hits[b] >= 2) coll = 1'b1;
               exp_w[t + 1] = w;
               if (coll) coll_set[t + 1] = 1'b1;
               m_cnt++;
               if (m_cnt == int'(cnt_wr_stop)) begin
                  m_mode = 2;
                  exp_end[t + 1] = 1'b1;
               end
            end
         default: m_mode = 0;
      endcase
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_lanes(input logic [2:0] f, input logic [0:4][2:0] idx);
      in_valid = 1'b1;
      in_factor = f;
      in_bank_index = idx;
      for (int k = 0; k < 5; k++) begin
         in_bank_addr[k] = WA'($urandom);
         in_real[k]      = WD'($urandom);
         in_imag[k]      = WD'($urandom);
      end
   endtask

   initial begin
      logic [0:4][2:0] idx;
      logic [WA-1:0]   save_addr3;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_wren_lit", 64'(wren), 64'd0);
      chk("rst_beat_cnt_lit", 64'(beat_cnt), 64'd0);
      chk("rst_busy_lit", 64'(wr_busy), 64'd0);
      rst_n = 1'b1;
      tick();

      // Radix-5 stage, 4 beats
      cnt_wr_stop = 12'd4; start = 1'b1; tick(); start = 1'b0;
      chk("r5_busy_lit", 64'(wr_busy), 64'd1);
      idx = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      for (int i = 0; i < 4; i++) begin
         set_lanes(3'd5, idx);
         save_addr3 = in_bank_addr[3];
         tick();
      end
      in_valid = 1'b0;
      chk("r5_beat_cnt_lit", 64'(beat_cnt), 64'd4);
      tick();
      chk("r5_wr_end_lit", 64'(wr_end), 64'd1);
      chk("r5_nwren_lit", 64'($countones(wren)), 64'd5);
      chk("r5_addr3", 64'(wraddr[3]), 64'(save_addr3));
      tick();
      chk("r5_idle_lit", 64'(wr_busy), 64'd0);

      // Radix-3 with invalid lanes
      cnt_wr_stop = 12'd2; start = 1'b1; tick(); start = 1'b0;
      set_lanes(3'd3, {3'd0, 3'd1, 3'd2, 3'd5, 3'd6}); tick();
      set_lanes(3'd3, {3'd3, 3'd7, 3'd4, 3'd5, 3'd6}); tick();
      chk("r3_nwren_a_lit", 64'($countones(wren)), 64'd3);
      chk("r3_bank56_lit", 64'({wren[5], wren[6]}), 64'd0);
      in_valid = 1'b0; tick();
      chk("r3_nwren_b_lit", 64'($countones(wren)), 64'd2);
      chk("r3_wr_end_lit", 64'(wr_end), 64'd1);
      tick();

      // Collision on bank 4
      cnt_wr_stop = 12'd1; start = 1'b1; tick(); start = 1'b0;
      set_lanes(3'd5, {3'd4, 3'd0, 3'd4, 3'd1, 3'd2});
      in_bank_addr[0] = 9'h10; in_bank_addr[2] = 9'h22;
      in_real[0] = 18'h01234; in_imag[0] = 18'h2abcd;
      tick();
      in_valid = 1'b0; tick();
      chk("coll_addr4_lit", 64'(wraddr[4]), 64'h10);
      chk("coll_re4_lit", 64'(wdata_real[4]), 64'h01234);
      chk("coll_im4_lit", 64'(wdata_imag[4]), 64'h2abcd);
      chk("coll_flag_lit", 64'(collision_err), 64'(COLL_ON));
      tick(); tick();
      cnt_wr_stop = 12'd1; start = 1'b1; tick(); start = 1'b0;
      chk("coll_clear_lit", 64'(collision_err), 64'd0);
      set_lanes(3'd2, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}); tick();
      in_valid = 1'b0; tick(); tick();

      // Gated beats in IDLE and FLUSH
      set_lanes(3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}); tick(); tick();
      in_valid = 1'b0; tick();
      chk("gate_idle_wren_lit", 64'(wren), 64'd0);
      chk("gate_idle_cnt_lit", 64'(beat_cnt), 64'd1);
      cnt_wr_stop = 12'd0; start = 1'b1; tick(); start = 1'b0;
      set_lanes(3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}); tick();
      chk("zero_wr_end_lit", 64'(wr_end), 64'd1);
      in_valid = 1'b0; tick();
      chk("zero_wren_lit", 64'(wren), 64'd0);
      chk("zero_cnt_lit", 64'(beat_cnt), 64'd0);

      // Reset mid-stage
      cnt_wr_stop = 12'd6; start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_lanes(3'd4, {3'd6, 3'd5, 3'd3, 3'd0, 3'd1}); tick();
      end
      in_valid = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("mrst_wren_lit", 64'(wren), 64'd0);
      chk("mrst_busy_lit", 64'(wr_busy), 64'd0);
      chk("mrst_cnt_lit", 64'(beat_cnt), 64'd0);
      repeat (4) tick();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_lanes(3'd5, {3'd2, 3'd3, 3'd4, 3'd5, 3'd6}); tick();
      end
      in_valid = 1'b0; tick();
      chk("mrst_fresh_end_lit", 64'(wr_end), 64'd1);
      tick();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 149) != 0);
         start = ($urandom_range(0, 5) == 0);
         if (m_mode == 0) cnt_wr_stop = 12'($urandom_range(0, 8));
         for (int k = 0; k < 5; k++) idx[k] = 3'($urandom_range(0, 7));
         set_lanes(3'($urandom_range(0, 7)), idx);
         in_valid = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
      repeat (6) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
